z_seq_add_ctrl: RTL and testbench

- Multi-cycle N-bit adder controller, N = M*K.
- Time-shares one M-bit z_m_sca_stage slice adder across K operand chunks, LSB chunk first, with the carry registered between chunks.
- Trades area for latency. Front end for wide adds in the Project 3 datapath.
- Uses a start/busy request handshake on the input side and a valid/ready handshake on the output side.

---
 rtl/z_seq_add_ctrl_pkg.sv | 15 +
 rtl/z_m_sca_stage.sv | 20 ++
 rtl/z_seq_add_ctrl.sv | 96 +++++++++
 tb/tb_z_seq_add_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/z_seq_add_ctrl_pkg.sv
// Shared state encoding and default geometry for the sequential slice adder.
package z_seq_add_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_M = 4;
  localparam int DEF_K = 4;

  function automatic int cnt_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction
endpackage

// File: rtl/z_m_sca_stage.sv
// M-bit slice adder: per-bit full adders chained through a carry vector.
module z_m_sca_stage #(
  parameter int M = 4
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         c_in,
  output logic [M-1:0] sum,
  output logic         c_out
);
  logic [M:0] c;
  assign c[0] = c_in;

  for (genvar i = 0; i < M; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[M];
endmodule

// File: rtl/z_seq_add_ctrl.sv
// N = M*K bit adder that reuses one M-bit slice for K cycles, LSB chunk first,
// with start/busy on the request side and valid/ready on the result side.
module z_seq_add_ctrl
  import z_seq_add_ctrl_pkg::*;
#(
  parameter int M  = DEF_M,
  parameter int K  = DEF_K,
  parameter int CW = cnt_w(K),
  localparam int N = M * K
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf
);
  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic           carry, sa, sb;
  logic [N-1:0]   a_sh, b_sh, sum_sh;
  logic [M-1:0]   slice_sum;
  logic           slice_co;
  logic           last;

  assign last = (cnt == CW'(K - 1));

  z_m_sca_stage #(.M(M)) u_slice (
    .a    (a_sh[M-1:0]),
    .b    (b_sh[M-1:0]),
    .c_in (carry),
    .sum  (slice_sum),
    .c_out(slice_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)     state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Result bits enter at the top of sum_sh so after K shifts chunk 0 sits at the LSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh   <= a;
          b_sh   <= b;
          carry  <= c_in;
          sa     <= a[N-1];
          sb     <= b[N-1];
          sum_sh <= '0;
          cnt    <= '0;
        end
        RUN: begin
          sum_sh <= {slice_sum, sum_sh[N-1:M]};
          a_sh   <= a_sh >> M;
          b_sh   <= b_sh >> M;
          carry  <= slice_co;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_sh;
  assign c_out     = carry;
  // The slice hides the carry into the MSB, so overflow comes from the saved sign bits.
  assign ovf       = (sa == sb) && (sum_sh[N-1] != sa);
endmodule

// File: tb/tb_z_seq_add_ctrl.sv
// Randomized and directed bench for z_seq_add_ctrl against a transaction-level model.
module tb_z_seq_add_ctrl;
  localparam int M = 4;
  localparam int K = 4;
  localparam int N = M * K;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, c_in = 1'b0, out_ready = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic         busy, out_valid, c_out, ovf;
  logic [N-1:0] sum;

  int checks = 0, failures = 0;
  bit run_chk = 1'b0;

  // Model state: whether an op is in flight, cycles until its result, and the result.
  bit           m_busy = 1'b0, m_valid = 1'b0;
  int           m_cd = 0;
  logic [N-1:0] m_sum = '0;
  logic         m_c = 1'b0, m_ovf = 1'b0;

  z_seq_add_ctrl #(.M(M), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    logic [N:0] t;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_busy = 0; m_valid = 0; m_sum = '0; m_c = 0; m_ovf = 0;
      end else if (!m_busy && start) begin
        t      = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
        m_sum  = t[N-1:0];
        m_c    = t[N];
        m_ovf  = (a[N-1] == b[N-1]) && (t[N-1] != a[N-1]);
        m_busy = 1; m_cd = K;
      end else if (m_busy && !m_valid) begin
        m_cd--;
        if (m_cd == 0) m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0; m_busy = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (run_chk) begin
        chk("busy", busy, m_busy);
        chk("out_valid", out_valid, m_valid);
        if (!m_busy || m_valid) begin
          chk("sum", sum, m_sum);
          chk("c_out", c_out, m_c);
          chk("ovf", ovf, m_ovf);
        end
      end
    end
  end

  task automatic op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc,
                    input int hold, output logic [N-1:0] rs, output logic rc,
                    output logic ro, output int lat, output int bcnt);
    int hc;
    @(posedge clk); #1;
    a = ta; b = tb; c_in = tc; start = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    lat = -1; bcnt = 0; hc = 0; rs = 'x; rc = 1'bx; ro = 1'bx;
    for (int i = 0; i < 40 && busy; i++) begin
      bcnt++;
      start = 1'b0;
      if (out_valid) begin
        if (lat < 0) lat = i;
        if (hc == 1) begin
          start = 1'b1; a = N'($urandom); b = N'($urandom); c_in = 1'($urandom);
        end
        if (hc >= hold) begin
          out_ready = 1'b1; rs = sum; rc = c_out; ro = ovf;
        end
        hc++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; out_ready = 1'b0;
    if (busy) chk("op_timeout", 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [N-1:0] a, b;
    logic         ci;
    int           hold;
    logic [N-1:0] s;
    logic         c, o;
  } vec_t;

  vec_t vecs [6] = '{
    '{16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0},
    '{16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1},
    '{16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1},
    '{16'h0A0B, 16'h1C1D, 1'b0, 3, 16'h2628, 1'b0, 1'b0}
  };

  initial begin
    logic [N-1:0] rs;
    logic rc, ro;
    int lat, bcnt, n;

    repeat (2) @(posedge clk);
    #1 run_chk = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_c_out", c_out, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].hold, rs, rc, ro, lat, bcnt);
      chk($sformatf("v%0d_sum", i), rs, vecs[i].s);
      chk($sformatf("v%0d_c_out", i), rc, vecs[i].c);
      chk($sformatf("v%0d_ovf", i), ro, vecs[i].o);
      chk($sformatf("v%0d_latency", i), lat, K);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, K + 1 + vecs[i].hold);
    end

    // Reset lands on the second RUN edge.
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; c_in = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_sum", sum, 16'h0000);
    rst_n = 1'b1;
    op(16'h0F0F, 16'h00F1, 1'b0, 0, rs, rc, ro, lat, bcnt);
    chk("post_rst_sum", rs, 16'h1000);
    chk("post_rst_c_out", rc, 1'b0);
    chk("post_rst_latency", lat, K);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start     = ($urandom_range(2) == 0);
      out_ready = ($urandom_range(1) == 0);
      a         = N'($urandom);
      b         = N'($urandom);
      c_in      = 1'($urandom);
    end
    start = 1'b0; out_ready = 1'b1;
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    if (busy) chk("drain_timeout", 1'b1, 1'b0);

    @(negedge clk);
    run_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
